fetch_unit: RTL and testbench

Parametrised instruction fetch unit for the accumulator processor. It replaces the single-shot PC/IR fetch path with a prefetching front end. It owns the program counter and arbitrates a single synchronous memory port between instruction fetch and control-issued data accesses, with data taking priority. Fetched words go into a DEPTH-entry queue and are handed to the control unit over a valid/ready handshake. Branch redirects flush the queue and any fetch still in flight.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 97 +++++++++
 tb/tb_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the prefetching instruction front end.
package fetch_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;
    localparam logic [15:0] DEF_RESET_PC = 16'h0000;

    // Kind of response the memory returns in the next cycle.
    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DATA  = 2'd2
    } tag_e;

endpackage

// File: rtl/fetch_unit_if.sv
// Control-side, memory-side and redirect signals of the fetch unit.
// Handshake: an instruction moves only in a cycle where ir_valid & ir_ready are both 1.
interface fetch_unit_if import fetch_pkg::*; #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_data;
    logic [ADDR_W-1:0] ir_pc;
    logic              ir_ready;
    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic [DATA_W-1:0] data_rdata;
    logic              data_rvalid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  redirect_valid, redirect_pc, ir_ready,
        input  data_req, data_we, data_addr, data_wdata, mem_rdata,
        output ir_valid, ir_data, ir_pc, data_rdata, data_rvalid,
        output mem_addr, mem_we, mem_wdata
    );

    modport slave (
        output redirect_valid, redirect_pc, ir_ready,
        output data_req, data_we, data_addr, data_wdata, mem_rdata,
        input  ir_valid, ir_data, ir_pc, data_rdata, data_rvalid,
        input  mem_addr, mem_we, mem_wdata
    );

endinterface

// File: rtl/fetch_queue.sv
// Power-of-two FIFO for prefetched {instruction, pc} pairs; flush wins over push and pop.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_flush,
    input  logic [WIDTH-1:0]         i_data,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pop_ok;
    logic             w_push_ok;

    assign w_pop_ok  = i_pop && (r_count != '0);
    // A pop in the same cycle frees the slot a push into a full queue needs.
    assign w_push_ok = i_push && ((r_count != CW'(DEPTH)) || w_pop_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Prefetching fetch front end: owns the PC, shares one memory port with data
// accesses (data first), queues fetched words and flushes them on redirect.
module fetch_unit import fetch_pkg::*; #(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fetch_unit_if.master           io_bus,
    output logic [ADDR_W-1:0]      o_fetch_pc,
    output logic [$clog2(DEPTH):0] o_queue_count,
    output tag_e                   o_tag
);

    localparam int CW = $clog2(DEPTH) + 1;

    tag_e                     r_tag;
    tag_e                     w_tag_nxt;
    logic [ADDR_W-1:0]        r_tag_pc;
    logic [ADDR_W-1:0]        r_fetch_pc;
    logic                     w_q_valid;
    logic [DATA_W+ADDR_W-1:0] w_q_data;
    logic [CW-1:0]            w_q_count;
    logic                     w_pop;
    logic                     w_inflight;
    logic                     w_rvalid;
    logic                     w_push;
    logic                     w_room;
    logic                     w_issue;

    assign w_pop  = w_q_valid & io_bus.ir_ready;
    // Slot check is count + inflight - pop < DEPTH, rearranged to avoid underflow.
    assign w_room = ({1'b0, w_q_count} + (CW+1)'(w_inflight)) <
                    ((CW+1)'(DEPTH) + (CW+1)'(w_pop));
    assign w_issue = !io_bus.redirect_valid && !io_bus.data_req && w_room;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_tag <= TAG_NONE;
        else        r_tag <= w_tag_nxt;
    end

    always_comb begin
        w_tag_nxt = TAG_NONE;
        if (io_bus.data_req) w_tag_nxt = io_bus.data_we ? TAG_NONE : TAG_DATA;
        else if (w_issue)    w_tag_nxt = TAG_FETCH;
    end

    always_comb begin
        w_inflight = (r_tag == TAG_FETCH);
        w_rvalid   = (r_tag == TAG_DATA);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_tag_pc   <= '0;
        end else begin
            if (io_bus.redirect_valid) r_fetch_pc <= io_bus.redirect_pc;
            else if (w_issue)          r_fetch_pc <= r_fetch_pc + 1'b1;
            if (w_issue)               r_tag_pc   <= r_fetch_pc;
        end
    end

    // A fetch response landing in a redirect cycle belongs to the old path.
    assign w_push = w_inflight && !io_bus.redirect_valid;

    fetch_queue #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (io_bus.redirect_valid),
        .i_data  ({io_bus.mem_rdata, r_tag_pc}),
        .o_data  (w_q_data),
        .o_valid (w_q_valid),
        .o_count (w_q_count)
    );

    assign io_bus.mem_addr    = io_bus.data_req ? io_bus.data_addr : r_fetch_pc;
    assign io_bus.mem_we      = rst_n & io_bus.data_req & io_bus.data_we;
    assign io_bus.mem_wdata   = io_bus.data_wdata;
    assign io_bus.ir_valid    = w_q_valid;
    assign io_bus.ir_data     = w_q_data[DATA_W+ADDR_W-1:ADDR_W];
    assign io_bus.ir_pc       = w_q_data[ADDR_W-1:0];
    assign io_bus.data_rdata  = io_bus.mem_rdata;
    assign io_bus.data_rvalid = w_rvalid;

    assign o_fetch_pc    = r_fetch_pc;
    assign o_queue_count = w_q_count;
    assign o_tag         = r_tag;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized checks of fetch_unit against an in-order stream model
// and a data-memory model.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam logic [15:0] RESET_PC = 16'h0000;

    // clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
    logic [15:0] fetch_pc;
    logic [2:0]  queue_count;
    tag_e        tag;

    fetch_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .io_bus        (bus.master),
        .o_fetch_pc    (fetch_pc),
        .o_queue_count (queue_count),
        .o_tag         (tag)
    );

    // external synchronous memory, one-cycle read latency
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // scoreboard state
    int          checks = 0;
    int          errors = 0;
    int          n_pop  = 0;
    logic [15:0] m_next_pc;
    logic        m_rd_due;
    logic [15:0] exp_q [$];
    logic [15:0] dmodel [logic [15:0]];
    logic [15:0] fp_save;
    logic [15:0] wv;
    logic [15:0] dummy;

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return (a == 16'h0200) ? 16'hBEEF : 16'h1000 + a;
    endfunction

    function automatic logic [15:0] exp_read(input logic [15:0] a);
        if (dmodel.exists(a)) return dmodel[a];
        return init_word(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_next_pc = RESET_PC;
        m_rd_due  = 1'b0;
        exp_q.delete();
    endtask

    task automatic clear_inputs();
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.data_req       = 1'b0;
        bus.data_we        = 1'b0;
        bus.data_addr      = '0;
        bus.data_wdata     = '0;
    endtask

    // checks one cycle against the model, then moves to just after the next edge
    task automatic adv();
        #1;
        chk("rvalid", bus.data_rvalid, m_rd_due);
        if (m_rd_due) begin
            dummy = exp_q.pop_front();
            if (bus.data_rvalid) chk("rdata", bus.data_rdata, dummy);
        end
        chk("ir_valid_vs_count", bus.ir_valid, queue_count != 0);
        chk("count_bound", queue_count <= DEPTH, 1);
        chk("mem_we", bus.mem_we, bus.data_req & bus.data_we);
        if (bus.data_req) chk("mem_addr_data", bus.mem_addr, bus.data_addr);
        if (bus.ir_valid && bus.ir_ready) begin
            chk("ir_pc", bus.ir_pc, m_next_pc);
            chk("ir_data", bus.ir_data, init_word(m_next_pc));
            m_next_pc = m_next_pc + 1'b1;
            n_pop++;
        end
        if (bus.redirect_valid) m_next_pc = bus.redirect_pc;
        m_rd_due = bus.data_req & !bus.data_we;
        if (m_rd_due) exp_q.push_back(exp_read(bus.data_addr));
        if (bus.data_req & bus.data_we) dmodel[bus.data_addr] = bus.data_wdata;
        @(posedge clk);
        #1;
    endtask

    // returns just after the edge that ends reset; the current cycle is the first one
    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = init_word(16'(i));
        clear_inputs();
        bus.ir_ready = 1'b0;
        model_reset();

        // reset state, with a write request held during reset
        bus.data_req = 1'b1;
        bus.data_we  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ir_valid", bus.ir_valid, 0);
        chk("rst_qcount", queue_count, 0);
        chk("rst_rvalid", bus.data_rvalid, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_fetch_pc", fetch_pc, RESET_PC);
        chk("rst_tag", tag, TAG_NONE);
        clear_inputs();

        // straight-line fetch
        bus.ir_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        chk("sl_first_addr", bus.mem_addr, RESET_PC);
        chk("sl_c0_valid", bus.ir_valid, 0);
        adv();
        chk("sl_c1_pc", fetch_pc, 16'h0001);
        chk("sl_c1_valid", bus.ir_valid, 0);
        adv();
        chk("sl_c2_valid", bus.ir_valid, 1);
        chk("sl_c2_pc", bus.ir_pc, 16'h0000);
        chk("sl_c2_data", bus.ir_data, 16'h1000);
        repeat (8) begin
            chk("sl_stream_valid", bus.ir_valid, 1);
            adv();
        end

        // back-pressure from reset
        bus.ir_ready = 1'b0;
        do_reset();
        repeat (8) adv();
        chk("bp_count", queue_count, 4);
        chk("bp_fetch_pc", fetch_pc, 16'h0004);
        chk("bp_no_issue", tag, TAG_NONE);
        chk("bp_ir_pc", bus.ir_pc, 16'h0000);
        chk("bp_ir_data", bus.ir_data, 16'h1000);
        bus.ir_ready = 1'b1;
        n_pop = 0;
        repeat (12) adv();
        chk("bp_resume_pops", n_pop, 12);

        // redirect while the response for 0x0005 is pending
        do_reset();
        for (int k = 0; k < 20 && fetch_pc != 16'h0006; k++) adv();
        chk("rd_reach", fetch_pc, 16'h0006);
        chk("rd_inflight", tag, TAG_FETCH);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0040;
        adv();
        bus.redirect_valid = 1'b0;
        #1;
        chk("rd_n1_valid", bus.ir_valid, 0);
        chk("rd_n1_issue", bus.mem_addr, 16'h0040);
        adv();
        chk("rd_n2_valid", bus.ir_valid, 0);
        adv();
        chk("rd_n3_valid", bus.ir_valid, 1);
        chk("rd_n3_pc", bus.ir_pc, 16'h0040);
        adv();
        repeat (3) adv();

        // data priority: read, write, read back
        fp_save = fetch_pc;
        bus.data_req  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 16'h0200;
        #1;
        chk("dp_mem_addr", bus.mem_addr, 16'h0200);
        adv();
        bus.data_req = 1'b0;
        #1;
        chk("dp_no_issue", fetch_pc, fp_save);
        chk("dp_rvalid", bus.data_rvalid, 1);
        chk("dp_rdata", bus.data_rdata, 16'hBEEF);
        adv();
        wv = 16'($urandom);
        bus.data_req   = 1'b1;
        bus.data_we    = 1'b1;
        bus.data_addr  = 16'h8001;
        bus.data_wdata = wv;
        #1;
        chk("dw_mem_we", bus.mem_we, 1);
        chk("dw_mem_wdata", bus.mem_wdata, wv);
        adv();
        bus.data_req = 1'b0;
        bus.data_we  = 1'b0;
        #1;
        chk("dw_mem_we_off", bus.mem_we, 0);
        chk("dw_no_rvalid", bus.data_rvalid, 0);
        adv();
        bus.data_req  = 1'b1;
        bus.data_addr = 16'h8001;
        adv();
        bus.data_req = 1'b0;
        #1;
        chk("dw_readback", bus.data_rdata, wv);
        repeat (4) adv();

        // wrap at the top of the address space
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFF;
        adv();
        bus.redirect_valid = 1'b0;
        adv();
        adv();
        chk("wrap_valid", bus.ir_valid, 1);
        chk("wrap_pc_ffff", bus.ir_pc, 16'hFFFF);
        adv();
        chk("wrap_pc_0000", bus.ir_pc, 16'h0000);
        adv();

        // randomized traffic
        n_pop = 0;
        for (int c = 0; c < 400; c++) begin
            bus.ir_ready       = ($urandom_range(0, 3) != 0);
            bus.data_req       = ($urandom_range(0, 7) == 0);
            bus.data_we        = 1'($urandom_range(0, 1));
            bus.data_addr      = 16'h8000 + 16'($urandom_range(0, 7));
            bus.data_wdata     = 16'($urandom);
            bus.redirect_valid = ($urandom_range(0, 19) == 0);
            bus.redirect_pc    = ($urandom_range(0, 1) != 0) ? 16'($urandom_range(0, 255))
                                                             : 16'hFFF8 + 16'($urandom_range(0, 7));
            adv();
        end
        clear_inputs();
        chk("rand_progress", n_pop > 100, 1);

        // reset mid-operation: three queued entries plus one fetch in flight
        bus.ir_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 20 && queue_count != 3'd3; k++) adv();
        chk("mr_count", queue_count, 3);
        chk("mr_inflight", tag, TAG_FETCH);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_ir_valid", bus.ir_valid, 0);
        chk("mr_count0", queue_count, 0);
        chk("mr_rvalid", bus.data_rvalid, 0);
        chk("mr_fetch_pc", fetch_pc, RESET_PC);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.ir_ready = 1'b1;
        #1;
        chk("mr_restart_addr", bus.mem_addr, RESET_PC);
        adv();
        adv();
        chk("mr_restart_valid", bus.ir_valid, 1);
        chk("mr_restart_pc", bus.ir_pc, RESET_PC);
        repeat (4) adv();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
